// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate pipeline.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mul_add.sv
// Tiny-float multiply and add, purely combinational.
module fp_mul_add
    import mac_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [EXP_W+MAN_W:0] mul_a,
    input  logic [EXP_W+MAN_W:0] mul_b,
    input  logic [EXP_W+MAN_W:0] add_a,
    input  logic [EXP_W+MAN_W:0] add_b,
    output logic [EXP_W+MAN_W:0] prod,
    output logic                 prod_ovf,
    output logic [EXP_W+MAN_W:0] sum,
    output logic                 sum_ovf
);

    localparam int W    = EXP_W + MAN_W + 1;
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int BIAS = calc_bias(EXP_W);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-2:0] MAG_MAX = '1;

    // Returns {overflow, encoded value}; e <= 0 flushes to +0.
    function automatic logic [W:0] pack(
        input logic                 s,
        input logic signed [XW-1:0] e,
        input logic [MAN_W-1:0]     m
    );
        if (e <= 0)
            return '0;
        else if (e > EMAX)
            return {1'b1, s, MAG_MAX};
        else
            return {1'b0, s, e[EXP_W-1:0], m};
    endfunction

    logic [PW-1:0]          ma_x, mb_x, mp;
    logic signed [XW-1:0]   pe;
    logic [MAN_W-1:0]       pm;

    always_comb begin
        ma_x = PW'({1'b1, mul_a[MAN_W-1:0]});
        mb_x = PW'({1'b1, mul_b[MAN_W-1:0]});
        mp   = ma_x * mb_x;
        pe   = XW'(mul_a[W-2:MAN_W]) + XW'(mul_b[W-2:MAN_W])
             - XW'(BIAS);
        if (mp[PW-1]) begin
            pm = mp[PW-2 -: MAN_W];
            pe = pe + XW'(1);
        end else begin
            pm = mp[PW-3 -: MAN_W];
        end
        if (mul_a[W-2:MAN_W] == '0 || mul_b[W-2:MAN_W] == '0)
            pe = '0;
        {prod_ovf, prod} = pack(mul_a[W-1] ^ mul_b[W-1], pe, pm);
    end

    logic                 a_big, sl, ss;
    logic [EXP_W-1:0]     el, es;
    logic [MAN_W-1:0]     fl, fs, sf;
    logic [MAN_W:0]       ml, ms;
    logic [MAN_W+1:0]     sm, sn;
    logic signed [XW-1:0] se;
    int                   lz;

    always_comb begin
        a_big = add_a[W-2:0] >= add_b[W-2:0];
        {sl, el, fl} = a_big ? add_a : add_b;
        {ss, es, fs} = a_big ? add_b : add_a;
        ml = (el != '0) ? {1'b1, fl} : '0;
        ms = (es != '0) ? {1'b1, fs} : '0;
        ms = ms >> (el - es);
        if (sl == ss)
            sm = {1'b0, ml} + {1'b0, ms};
        else
            sm = {1'b0, ml} - {1'b0, ms};
        se = XW'(el);
        lz = 0;
        sn = '0;
        for (int i = 0; i <= MAN_W; i++)
            if (sm[i]) lz = MAN_W - i;
        if (sm[MAN_W+1]) begin
            sf = sm[MAN_W -: MAN_W];
            se = se + XW'(1);
        end else begin
            sn = sm << lz;
            sf = sn[MAN_W-1:0];
            se = se - XW'(lz);
        end
        if (sm == '0)
            se = '0;
        {sum_ovf, sum} = pack(sl, se, sf);
    end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate with integer/float modes
// and a valid/ready result handshake.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             float_mode,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] weight,
    input  logic [WIDTH-1:0] value,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_overflow
);

    localparam int MAN_W = WIDTH - 1 - EXP_W;
    localparam int PW    = 2 * WIDTH;
    localparam logic signed [PW:0] IMAX =
        (PW+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [PW:0] IMIN = ~IMAX;

    state_t            state;
    logic              s1_valid, s1_last, s1_ovf;
    logic [PW-1:0]     s1_prod;
    logic [WIDTH-1:0]  acc;
    logic              ovf;
    logic              accept;

    logic [WIDTH-1:0]  f_prod, f_sum;
    logic              f_prod_ovf, f_sum_ovf;

    logic signed [PW-1:0] w_ext, v_ext, i_prod;
    logic signed [PW:0]   i_sum;
    logic [WIDTH-1:0]     i_res;
    logic                 i_ovf;

    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == HOLD);
    assign out_acc      = acc;
    assign out_overflow = ovf;
    assign accept       = in_valid && in_ready;

    fp_mul_add #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_fp (
        .mul_a    (weight),
        .mul_b    (value),
        .add_a    (acc),
        .add_b    (s1_prod[WIDTH-1:0]),
        .prod     (f_prod),
        .prod_ovf (f_prod_ovf),
        .sum      (f_sum),
        .sum_ovf  (f_sum_ovf)
    );

    // Full-width signed sum, clamped back into WIDTH bits.
    always_comb begin
        w_ext  = {{WIDTH{weight[WIDTH-1]}}, weight};
        v_ext  = {{WIDTH{value[WIDTH-1]}}, value};
        i_prod = w_ext * v_ext;
        i_sum  = {s1_prod[PW-1], s1_prod}
               + {{(PW+1-WIDTH){acc[WIDTH-1]}}, acc};
        i_ovf  = 1'b1;
        if (i_sum > IMAX)
            i_res = IMAX[WIDTH-1:0];
        else if (i_sum < IMIN)
            i_res = IMIN[WIDTH-1:0];
        else begin
            i_res = i_sum[WIDTH-1:0];
            i_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            state    <= ACCUM;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_prod  <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_ovf  <= float_mode & f_prod_ovf;
                s1_prod <= float_mode ? {{WIDTH{1'b0}}, f_prod}
                                      : i_prod;
            end
            if (s1_valid) begin
                acc <= float_mode ? f_sum : i_res;
                ovf <= ovf | s1_ovf
                     | (float_mode ? f_sum_ovf : i_ovf);
            end
            unique case (state)
                ACCUM:
                    if (accept && in_last) state <= DRAIN;
                DRAIN:
                    if (s1_valid && s1_last) state <= HOLD;
                HOLD:
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                default:
                    state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe, WIDTH=8 / EXP_W=4.
module tb_mac_pipe;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       float_mode = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] weight = '0;
    logic [7:0] value = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_acc;
    logic       out_overflow;

    int total = 0;
    int bad = 0;

    logic [8:0] exp_q[$];
    logic [7:0] m_acc = '0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    mac_pipe #(
        .WIDTH (8),
        .EXP_W (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .float_mode   (float_mode),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .weight       (weight),
        .value        (value),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_overflow (out_overflow)
    );

    task automatic model_step(input logic [7:0] w, input logic [7:0] v);
        int s;
        s = int'($signed(m_acc)) + int'($signed(w)) * int'($signed(v));
        if (s > 127) begin
            m_acc = 8'h7f;
            m_ovf = 1'b1;
        end else if (s < -128) begin
            m_acc = 8'h80;
            m_ovf = 1'b1;
        end else begin
            m_acc = 8'(s);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] v,
                        input logic last);
        int g = 0;
        @(negedge clk);
        weight   = w;
        value    = v;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_int(input logic [7:0] w, input logic [7:0] v,
                            input logic last);
        model_step(w, v);
        send(w, v, last);
        if (last) begin
            exp_q.push_back({m_ovf, m_acc});
            m_acc = '0;
            m_ovf = 1'b0;
        end
    endtask

    task automatic get_result(input string name);
        int g = 0;
        logic [8:0] e;
        @(negedge clk);
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_valid: out_valid=%b queued=%0d required=1",
                     name, out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (out_acc !== e[7:0]) begin
                bad++;
                $display("FAIL %s_acc: got=%h required=%h",
                         name, out_acc, e[7:0]);
            end
            total++;
            if (out_overflow !== e[8]) begin
                bad++;
                $display("FAIL %s_ovf: got=%b required=%b",
                         name, out_overflow, e[8]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready: got=%b required=1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid: got=%b required=0", out_valid);
        end
        if (out_acc !== 8'h00) begin
            bad++;
            $display("FAIL rst_acc: got=%h required=00", out_acc);
        end
        if (out_overflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_ovf: got=%b required=0", out_overflow);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_int_basic();
        push_int(8'd3, 8'd4, 1'b0);
        push_int(8'hfe, 8'd5, 1'b0);
        push_int(8'd7, 8'd1, 1'b1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_early: out_valid=%b required=0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL lat_2cyc: out_valid=%b required=1", out_valid);
        end
        get_result("int_basic");
    endtask

    task automatic test_int_sat();
        push_int(8'd100, 8'd100, 1'b1);
        get_result("sat_pos");
        push_int(8'h9c, 8'd100, 1'b1);
        get_result("sat_neg");
    endtask

    task automatic test_float();
        float_mode = 1'b1;
        send(8'h3c, 8'h40, 1'b0);
        send(8'h38, 8'h38, 1'b1);
        exp_q.push_back({1'b0, 8'h48});
        get_result("fp_sum");
        send(8'h00, 8'h40, 1'b1);
        exp_q.push_back({1'b0, 8'h00});
        get_result("fp_zero");
        send(8'h38, 8'h38, 1'b0);
        send(8'hb8, 8'h38, 1'b1);
        exp_q.push_back({1'b0, 8'h00});
        get_result("fp_cancel");
        send(8'h08, 8'h08, 1'b1);
        exp_q.push_back({1'b0, 8'h00});
        get_result("fp_flush");
    endtask

    task automatic test_float_ovf();
        send(8'h7f, 8'h7f, 1'b1);
        exp_q.push_back({1'b1, 8'h7f});
        get_result("fp_ovf_pos");
        send(8'hff, 8'h7f, 1'b1);
        exp_q.push_back({1'b1, 8'hff});
        get_result("fp_ovf_neg");
        float_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        int g = 0;
        logic [8:0] e;
        push_int(8'd5, 8'd6, 1'b1);
        e = exp_q.pop_front();
        @(negedge clk);
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        weight   = 8'd9;
        value    = 8'd9;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_valid: got=%b required=1", out_valid);
            end
            if (out_acc !== e[7:0]) begin
                bad++;
                $display("FAIL bp_acc: got=%h required=%h",
                         out_acc, e[7:0]);
            end
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_in_ready: got=%b required=0", in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b required=1", in_ready);
        end
        model_step(8'd9, 8'd9);
        exp_q.push_back({m_ovf, m_acc});
        m_acc = '0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("bp_next");
    endtask

    task automatic test_clear_reset();
        int seen = 0;
        send(8'd4, 8'd4, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        clear    = 1'b1;
        weight   = 8'd1;
        value    = 8'd1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL clr_valid: out_valid cycles=%0d required=0", seen);
        end
        total++;
        if (out_acc !== 8'h00) begin
            bad++;
            $display("FAIL clr_acc: got=%h required=00", out_acc);
        end
        send(8'd9, 8'd9, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_mid_valid: cycles=%0d required=0", seen);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready: got=%b required=1", in_ready);
        end
        push_int(8'd2, 8'd3, 1'b1);
        get_result("after_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_int_basic();
        test_int_sat();
        test_float();
        test_float_ovf();
        test_backpressure();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and accumulator width.
REQ-002 The block SHALL have parameter EXP_W, default 4, meaning float exponent width; MAN_W = WIDTH-1-EXP_W is derived, and BIAS = 2^(EXP_W-1)-1.
REQ-003 clk  in  1  clock; one clock, all state on rising edge.
REQ-004 n_rst  in  1  synchronous, active-low reset.
REQ-005 float_mode  in  1  0 = signed two's-complement integer, 1 = float {sign, exp[EXP_W], man[MAN_W]}; only changed while idle or with clear.
REQ-006 clear  in  1  synchronous flush of pipeline, accumulator and flags.
REQ-007 in_valid  in  1  weight/value/in_last valid.
REQ-008 in_ready  out  1  block accepts a pair this cycle.
REQ-009 weight, value  in  WIDTH  operands.
REQ-010 in_last  in  1  final pair of the current sequence.
REQ-011 out_valid  out  1  out_acc holds a finished sequence result.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 out_acc  out  WIDTH  accumulated result.
REQ-014 out_overflow  out  1  sticky overflow/saturation for the reported sequence.

Function
REQ-015 A pair SHALL be accepted on a cycle with in_valid && in_ready.
REQ-016 Stage 1 SHALL register the product one cycle after acceptance; stage 2 SHALL update the accumulator the following cycle (2-cycle latency).
REQ-017 The FSM SHALL have states ACCUM, DRAIN and HOLD; in_ready = 1 only in ACCUM.
REQ-018 ACCUM->DRAIN on acceptance with in_last; DRAIN->HOLD when stage 2 absorbs the last product; HOLD->ACCUM on out_ready.
REQ-019 out_valid SHALL be 1 only in HOLD, with out_acc and out_overflow held stable until out_ready.
REQ-020 The HOLD->ACCUM transition SHALL zero the accumulator and overflow flag, so a new pair can be accepted the next cycle.
REQ-021 In integer mode, the full 2*WIDTH signed product plus sign-extended accumulator SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] on each step, setting overflow when saturated; saturation direction is the sign of the true sum.
REQ-022 In float mode, product sign = XOR of operand signs, product exponent = ew+ev-BIAS, and mantissa = (1.m)x(1.m) normalised by at most one shift and truncated.
REQ-023 Float addition SHALL align the smaller exponent by right shift (truncate), add or subtract magnitudes, renormalise, and take the sign of the larger magnitude.
REQ-024 Exponent field 0 SHALL encode zero: a zero operand yields a zero product, and any result with exponent <= 0 flushes to +0 without setting overflow.
REQ-025 A float result exponent above 2^EXP_W-1 SHALL saturate to the maximum magnitude with the correct sign and set overflow.
REQ-026 A result cancelling to exactly zero SHALL produce all-zero bits.
REQ-027 clear SHALL have priority over all other inputs: the next state is ACCUM with pipeline valids 0, accumulator 0, overflow 0 and out_valid 0, and the pair offered that cycle is not accepted.

Reset
REQ-028 While n_rst = 0 at a clock edge, the block SHALL set state ACCUM, in_ready 1, out_valid 0, out_acc 0, out_overflow 0 and pipeline valids 0; reset mid-sequence discards all partial data.

Structure
REQ-029 A package mac_pkg SHALL hold the state enum (ACCUM/DRAIN/HOLD) and a function computing BIAS.
REQ-030 Float multiply and float add SHALL live in one combinational sub-module, fp_mul_add, parametrised by EXP_W and MAN_W; integer arithmetic stays in mac_pipe.

Verification
REQ-031 Integer, WIDTH=8: pairs (3,4), (-2,5), (7,1, last) back-to-back -> out_valid 2 cycles after last acceptance, out_acc = 9, overflow 0.
REQ-032 Integer saturation: (100,100, last) -> out_acc = 127, overflow 1; next sequence (-100,100, last) -> out_acc = -128 (0x80), overflow 1.
REQ-033 Float, EXP_W=4: (0x3C,0x40) then (0x38,0x38, last) -> 3.0 + 1.0 -> out_acc = 0x48, overflow 0; (0x00,0x40, last) -> 0x00.
REQ-034 Float overflow: (0x7F,0x7F, last) -> out_acc = 0x7F, overflow 1.
REQ-035 Backpressure: out_ready held 0 for 3 cycles in HOLD -> out_acc stable, in_ready 0, in_valid ignored; out_ready = 1 -> next pair accepted the following cycle with accumulator 0.
REQ-036 clear asserted in DRAIN, and n_rst asserted mid-sequence -> no out_valid; the next sequence (2,3, last) -> out_acc = 6.
